// File: rtl/demux_sel_sequencer_if.sv
// Handshake and output bundle between a bit-stream source and demux_sel_sequencer.
// The driver side uses the master modport; the sequencer uses the slave modport.
interface demux_sel_sequencer_if;
  logic       start;
  logic [3:0] en_mask;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       i_out;
  logic [1:0] s_out;
  logic       out_valid;
  logic       busy;
  logic       frame_done;
  logic       dbg_state;

  modport master (
    output start, en_mask, in_bit, in_valid,
    input  in_ready, i_out, s_out, out_valid, busy, frame_done, dbg_state
  );

  modport slave (
    input  start, en_mask, in_bit, in_valid,
    output in_ready, i_out, s_out, out_valid, busy, frame_done, dbg_state
  );
endinterface

// File: rtl/demux_sel_sequencer.sv
// Burst-interleaving select sequencer feeding a 1-to-4 demux.
// Optional macro DEMUX_SEQ_AUTO_RESTART_EN: re-sample en_mask at frame end and continue without a bubble.
module demux_sel_sequencer #(
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_sel_sequencer_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_mask;
  logic [1:0]        r_chan;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_in_ready;
  logic              r_i_out;
  logic [1:0]        r_s_out;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_frame_done;

  logic              w_accept;
  logic              w_burst_end;
  logic              w_nxt_found;
  logic [1:0]        w_nxt_chan;
  logic [1:0]        w_low_chan;

  // Handshake: a bit transfers on a rising edge where in_valid && in_ready are both
  // high; in_ready is registered and high exactly while in RUN, independent of in_valid.
  assign w_accept    = bus.in_valid && r_in_ready;
  // Compare against BURST_LEN-1 so BURST_LEN == 2**BCNT_W never needs the wrapped value.
  assign w_burst_end = (r_bcnt == BCNT_W'(BURST_LEN - 1));

  always_comb begin
    w_nxt_found = 1'b0;
    w_nxt_chan  = r_chan;
    w_low_chan  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_mask[k] && (k > int'(r_chan))) begin
        w_nxt_found = 1'b1;
        w_nxt_chan  = 2'(k);
      end
      if (bus.en_mask[k]) begin
        w_low_chan = 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= 4'd0;
      r_chan       <= 2'd0;
      r_bcnt       <= '0;
      r_in_ready   <= 1'b0;
      r_i_out      <= 1'b0;
      r_s_out      <= 2'd0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_i_out      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.en_mask != 4'd0)) begin
            r_mask     <= bus.en_mask;
            r_chan     <= w_low_chan;
            r_bcnt     <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_i_out     <= bus.in_bit;
            r_s_out     <= r_chan;
            if (!w_burst_end) begin
              r_bcnt <= r_bcnt + 1'b1;
            end else begin
              r_bcnt <= '0;
              if (w_nxt_found) begin
                r_chan <= w_nxt_chan;
              end else begin
                r_frame_done <= 1'b1;
`ifdef DEMUX_SEQ_AUTO_RESTART_EN
                if (bus.en_mask != 4'd0) begin
                  r_mask <= bus.en_mask;
                  r_chan <= w_low_chan;
                end else begin
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                end
`else
                r_state    <= S_IDLE;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
`endif
              end
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.i_out      = r_i_out;
  assign bus.s_out      = r_s_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Scoreboard bench for demux_sel_sequencer: a frame-level model predicts every output bit,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_demux_sel_sequencer;
  localparam int BURST_LEN = 4;
  localparam int BCNT_W    = 2;
`ifdef DEMUX_SEQ_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  demux_sel_sequencer_if bus();

  demux_sel_sequencer #(.BURST_LEN(BURST_LEN), .BCNT_W(BCNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: entries are {frame_done, s_out[1:0], i_out}
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       seen_rst = 1'b0;
  logic       end_req  = 1'b0;
  logic       end_done = 1'b0;

  // frame-level reference model
  logic       m_active = 1'b0;
  int         m_k      = 0;
  int         m_nch    = 0;
  logic [1:0] m_chan[4];
  logic [1:0] m_last_s = 2'd0;

  task automatic load_frame(input logic [3:0] m);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        m_chan[n] <= 2'(k);
        n++;
      end
    end
    m_nch    <= n;
    m_k      <= 0;
    m_active <= 1'b1;
  endtask

  always @(posedge clk) begin
    logic lst;
    if (!rst_n) begin
      seen_rst <= 1'b1;
      m_active <= 1'b0;
      m_k      <= 0;
      m_last_s <= 2'd0;
    end else if (m_active) begin
      if (bus.in_valid) begin
        lst = ((m_k + 1) == m_nch * BURST_LEN);
        exp_q.push_back({lst, m_chan[m_k / BURST_LEN], bus.in_bit});
        m_last_s <= m_chan[m_k / BURST_LEN];
        m_k      <= m_k + 1;
        if (lst) begin
          if (AUTO && (bus.en_mask != 4'd0)) load_frame(bus.en_mask);
          else m_active <= 1'b0;
        end
      end
    end else if (bus.start && (bus.en_mask != 4'd0)) begin
      load_frame(bus.en_mask);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [3:0] e;
    if (seen_rst) begin
      chk("in_ready", 8'(bus.in_ready), 8'(m_active));
      chk("busy", 8'(bus.busy), 8'(m_active));
      chk("dbg_state", 8'(bus.dbg_state), 8'(m_active));
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 8'd1, 8'd0);
        end else begin
          e = exp_q.pop_front();
          chk("i_out", 8'(bus.i_out), 8'(e[0]));
          chk("s_out", 8'(bus.s_out), 8'(e[2:1]));
          chk("frame_done", 8'(bus.frame_done), 8'(e[3]));
        end
      end else begin
        chk("out_valid", 8'(bus.out_valid), 8'd0);
        chk("idle_i_out", 8'(bus.i_out), 8'd0);
        chk("idle_frame_done", 8'(bus.frame_done), 8'd0);
        chk("s_out_hold", 8'(bus.s_out), 8'(m_last_s));
      end
    end
    if (end_req && !end_done) begin
      chk("leftover_expected", 8'(exp_q.size()), 8'd0);
      end_done = 1'b1;
    end
  end

  // driver
  task automatic cyc(input logic r, input logic s, input logic [3:0] m, input logic v, input logic b);
    rst_n        = r;
    bus.start    = s;
    bus.en_mask  = m;
    bus.in_valid = v;
    bus.in_bit   = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input int n, input logic [3:0] pat, input bit toggle);
    int sent;
    int t;
    sent = 0;
    t = 0;
    while (sent < n) begin
      if (toggle && t[0]) begin
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      end else begin
        cyc(1'b1, 1'b0, 4'd0, 1'b1, pat[sent % 4]);
        sent++;
      end
      t++;
    end
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1101;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.en_mask = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2);

    // full mask, continuous stream
    cyc(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    send_bits(16, pat, 1'b0);
    idle(3);
    // sparse mask
    cyc(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0);
    send_bits(8, pat, 1'b0);
    idle(3);
    // stalled stream
    cyc(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    send_bits(16, pat, 1'b1);
    idle(3);
    // mid-frame reset, then a fresh frame
    cyc(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    send_bits(6, pat, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    send_bits(16, pat, 1'b0);
    idle(3);
    // ignored starts
    cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
    send_bits(3, pat, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    send_bits(4, pat, 1'b0);
    idle(3);
`ifdef DEMUX_SEQ_AUTO_RESTART_EN
    cyc(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 4'b0001, 1'b1, 1'($urandom_range(0, 1)));
    idle(3);
`endif
    // random traffic, including back-to-back starts and rare resets
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 5) == 0),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)));
    end
    idle(40);
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    if (!end_done) begin
      n_fail++;
      $display("FAIL end_check: got 0 expected 1");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
- Upstream driver for the 1-to-4 demultiplexer stage. Accepts a serial bit stream on a valid/ready handshake and produces the registered data bit `i_out` and channel select `s_out[1:0]` that feed the demux.
- Routes BURST_LEN consecutive bits to each enabled channel in ascending channel order, then ends the frame.
- Turns an unstructured bit stream into a per-channel burst-interleaved frame.

Parameters:
- BURST_LEN, 4: bits routed to one channel before advancing. Legal range is 1 to 2**BCNT_W.
- BCNT_W, 2: width of the burst counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  single-cycle request to begin a frame
- en_mask  input  4  channel enable mask; bit k enables channel k
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block accepts in_bit this cycle
- i_out  output  1  data bit to the demux input
- s_out  output  2  channel select to the demux
- out_valid  output  1  i_out/s_out carry an accepted bit
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse when the last bit of a frame is presented

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset is synchronous and active-low on `rst_n`, sampled on the rising edge of clk.
  - Reset has priority over everything, including mid-frame. Any in-flight frame is abandoned with no frame_done.
- Reset values:
  - state=IDLE
  - in_ready=0, i_out=0, s_out=2'b00, out_valid=0, busy=0, frame_done=0
  - burst counter=0, latched mask=0
- States: IDLE and RUN.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 with en_mask!=0: latch en_mask, load channel = lowest set bit of en_mask, clear burst counter, go to RUN.
  - start with en_mask==0 is ignored and the block stays in IDLE.
- RUN:
  - busy=1, in_ready=1.
  - start and en_mask changes are ignored.
  - A bit is accepted in cycle N when in_valid && in_ready.
  - Cycle N+1: i_out=in_bit, s_out=channel at acceptance, out_valid=1. Latency is exactly 1 cycle.
  - Cycle with no acceptance: next cycle out_valid=0 and i_out=0, so all demux outputs are low. s_out holds its last value.
- Advancing:
  - On each acceptance the burst counter increments.
  - On the BURST_LEN-th acceptance for a channel, the counter clears and the channel advances to the next higher set bit of the latched mask.
  - If no higher bit is set, the frame ends. The next state is IDLE, and frame_done=1 in cycle N+1 coincident with the last out_valid.
- Frame size: a frame is exactly BURST_LEN × popcount(mask) accepted bits.
- Stalls: in_valid low stalls the sequence with no state change. Gaps of any length are allowed.
- Back-to-back frames:
  - start may be asserted in the cycle frame_done is high; the new frame begins the following cycle.
  - in_ready is 0 for at least one cycle between non-auto-restart frames.
- Widths: the burst counter compare uses BCNT_W bits. BURST_LEN = 2**BCNT_W compares against wrap to 0 and must still terminate correctly.

Optional Feature:
- Macro: DEMUX_SEQ_AUTO_RESTART_EN.
- Defined: at frame end the block re-samples en_mask.
  - If en_mask is non-zero, it stays in RUN at the lowest set channel with the counter cleared. in_ready stays 1 with no bubble, and frame_done still pulses once per frame.
  - If en_mask is zero, it returns to IDLE.
- Not defined: the block always returns to IDLE at frame end and requires a new start.

Test Plan:
1. Reset, then start with en_mask=4'b1111 and 16 continuous valid bits 1,0,1,1,… → s_out sequence 0×4,1×4,2×4,3×4, each bit delayed one cycle; frame_done high in the cycle of the 16th out_valid; in_ready=0 the cycle after.
2. en_mask=4'b1010, BURST_LEN=4, 8 bits → s_out 1×4 then 3×4; channels 0 and 2 never selected; frame_done after bit 8.
3. Same as 1 with in_valid toggling 1,0,1,0 → out_valid=0 and i_out=0 on gap cycles; s_out holds; same channel order; frame_done after 16 accepts.
4. rst_n low for one cycle after 6 bits of a 4'b1111 frame → next cycle all outputs at reset values; no frame_done; a new start restarts at channel 0.
5. start with en_mask=0, and start pulsed while busy → no state change, busy unaffected, no frame_done.
6. With DEMUX_SEQ_AUTO_RESTART_EN, en_mask=4'b0001, 12 continuous bits → in_ready stays 1 throughout, s_out=0 throughout, frame_done pulses after bits 4, 8 and 12.
